// File: rtl/demux_seq_pkg.sv
// Shared types, sizes and the channel-search helper for the 1:8 DEMUX frame sequencer.
package demux_seq_pkg;

  typedef enum logic {IDLE, SCAN} seq_state_t;

  localparam int NUM_CHANNELS = 8;
  localparam int SEL_WIDTH    = 3;
  localparam int DWELL_WIDTH  = 8;

  // First enabled channel at or beyond start in scan direction; MSB of the result flags a hit.
  function automatic logic [SEL_WIDTH:0] seek_channel(
    input logic [NUM_CHANNELS-1:0] mask,
    input int                      start,
    input logic                    lsb_first
  );
    logic [SEL_WIDTH:0]   result;
    logic [SEL_WIDTH-1:0] pos;
    result = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pos = lsb_first ? SEL_WIDTH'(i) : SEL_WIDTH'(NUM_CHANNELS - 1 - i);
      if (!result[SEL_WIDTH] && mask[pos] &&
          (lsb_first ? (int'(pos) >= start) : (int'(pos) <= start))) begin
        result = {1'b1, pos};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_1_8_frame_sequencer_dwell.sv
// Dwell counter: load reloads DWELL_CYCLES-1, dec counts down, tc flags the last cycle of a dwell.
module demux_dwell_counter
  import demux_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic tc,
  output logic tc_next
);

  localparam logic [DWELL_WIDTH-1:0] RELOAD = DWELL_WIDTH'(DWELL_CYCLES - 1);

  logic [DWELL_WIDTH-1:0] count_r;
  logic [DWELL_WIDTH-1:0] count_next_s;

  // Next count: reload on a new channel, otherwise count down and hold at zero.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = RELOAD;
    end else if (dec && (count_r != '0)) begin
      count_next_s = count_r - DWELL_WIDTH'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign tc      = (count_r == '0);
  assign tc_next = (count_next_s == '0);

endmodule

// File: rtl/demux_1_8_frame_sequencer.sv
// Serialises 8-bit frames onto the 1:8 DEMUX Enable/Data/Select inputs, one channel per dwell.
// Optional CHANNEL_MASK_EN adds Channel_Mask_In; masked channels are skipped in zero cycles.
module demux_1_8_frame_sequencer
  import demux_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic       Clock_In,
  input  logic       Reset_N_In,
  input  logic       Frame_Valid_In,
  output logic       Frame_Ready_Out,
  input  logic [7:0] Frame_Data_In,
`ifdef CHANNEL_MASK_EN
  input  logic [7:0] Channel_Mask_In,
`endif
  output logic       Enable_Out,
  output logic       Data_Out,
  output logic [2:0] Select_Out,
  output logic       Frame_Done_Out,
  output logic       Busy_Out
);

  localparam logic LSB_MODE  = (LSB_FIRST != 0);
  localparam int   FIRST_POS = LSB_MODE ? 0 : NUM_CHANNELS - 1;

  seq_state_t                state_r, state_next_s;
  logic [SEL_WIDTH-1:0]      index_r, index_next_s;
  logic [NUM_CHANNELS-1:0]   shadow_r, shadow_next_s;
  logic [NUM_CHANNELS-1:0]   capture_mask_s, mask_cur_s, mask_next_s;
  logic [SEL_WIDTH:0]        first_s, after_s, after_next_s;
  logic accept_s, load_s, dec_s, empty_done_s, tc_s, tc_next_s;
  logic scan_next_s, last_next_s, done_next_s, ready_next_s;
  logic ready_r, enable_r, data_r, done_r, busy_r;
  logic [SEL_WIDTH-1:0] select_r;

  function automatic int step_from(input logic [SEL_WIDTH-1:0] idx);
    return LSB_MODE ? (int'(idx) + 32'sd1) : (int'(idx) - 32'sd1);
  endfunction

`ifdef CHANNEL_MASK_EN
  logic [NUM_CHANNELS-1:0] mask_r;
  assign capture_mask_s = Channel_Mask_In;
  assign mask_cur_s     = mask_r;
`else
  assign capture_mask_s = 8'hFF;
  assign mask_cur_s     = 8'hFF;
`endif

  assign accept_s = Frame_Valid_In && ready_r;
  assign first_s  = seek_channel(capture_mask_s, FIRST_POS, LSB_MODE);
  assign after_s  = seek_channel(mask_cur_s, step_from(index_r), LSB_MODE);

  demux_dwell_counter #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk     (Clock_In),
    .rst_n   (Reset_N_In),
    .load    (load_s),
    .dec     (dec_s),
    .tc      (tc_s),
    .tc_next (tc_next_s)
  );

  // Next-state logic: advance within a frame, or chain/accept a frame when the scan ends.
  always_comb begin
    state_next_s  = state_r;
    index_next_s  = index_r;
    shadow_next_s = shadow_r;
    mask_next_s   = mask_cur_s;
    load_s        = 1'b0;
    dec_s         = 1'b0;
    empty_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        index_next_s = '0;
        if (accept_s) begin
          shadow_next_s = Frame_Data_In;
          mask_next_s   = capture_mask_s;
          if (first_s[SEL_WIDTH]) begin
            state_next_s = SCAN;
            index_next_s = first_s[SEL_WIDTH-1:0];
            load_s       = 1'b1;
          end else begin
            empty_done_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (!tc_s) begin
          dec_s = 1'b1;
        end else if (after_s[SEL_WIDTH]) begin
          index_next_s = after_s[SEL_WIDTH-1:0];
          load_s       = 1'b1;
        end else if (accept_s) begin
          shadow_next_s = Frame_Data_In;
          mask_next_s   = capture_mask_s;
          if (first_s[SEL_WIDTH]) begin
            index_next_s = first_s[SEL_WIDTH-1:0];
            load_s       = 1'b1;
          end else begin
            state_next_s = IDLE;
            index_next_s = '0;
            empty_done_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
          index_next_s = '0;
        end
      end
      default: begin
        state_next_s = IDLE;
        index_next_s = '0;
      end
    endcase
  end

  assign after_next_s = seek_channel(mask_next_s, step_from(index_next_s), LSB_MODE);

  // Look ahead to the cycle being entered so Done and Ready can be registered.
  always_comb begin
    scan_next_s  = (state_next_s == SCAN);
    last_next_s  = !after_next_s[SEL_WIDTH];
    done_next_s  = (scan_next_s && tc_next_s && last_next_s) || empty_done_s;
    ready_next_s = (!scan_next_s && !empty_done_s) || (scan_next_s && tc_next_s && last_next_s);
  end

  // State, shadow and registered outputs.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_r  <= IDLE;
      index_r  <= '0;
      shadow_r <= '0;
      ready_r  <= 1'b0;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      select_r <= '0;
      data_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      index_r  <= index_next_s;
      shadow_r <= shadow_next_s;
      ready_r  <= ready_next_s;
      enable_r <= scan_next_s;
      busy_r   <= scan_next_s;
      select_r <= scan_next_s ? index_next_s : '0;
      data_r   <= scan_next_s ? shadow_next_s[index_next_s] : 1'b0;
      done_r   <= done_next_s;
    end
  end

`ifdef CHANNEL_MASK_EN
  // Captured channel mask.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      mask_r <= '0;
    end else begin
      mask_r <= mask_next_s;
    end
  end
`endif

  assign Frame_Ready_Out = ready_r;
  assign Enable_Out      = enable_r;
  assign Busy_Out        = busy_r;
  assign Select_Out      = select_r;
  assign Data_Out        = data_r;
  assign Frame_Done_Out  = done_r;

endmodule

// File: tb/tb_demux_1_8_frame_sequencer.sv
// Bench for demux_1_8_frame_sequencer: two instances (DWELL=1/LSB-first, DWELL=3/MSB-first) vs a queue model.
module tb_demux_1_8_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [2];
  logic       valid_v [2];
  logic [7:0] data_v  [2];
  logic [7:0] mask_v  [2];
  logic       ready_o [2];
  logic       en_o    [2];
  logic       dat_o   [2];
  logic       done_o  [2];
  logic       busy_o  [2];
  logic [2:0] sel_o   [2];

  int n_vec = 0;
  int n_err = 0;

  demux_1_8_frame_sequencer #(.DWELL_CYCLES(1), .LSB_FIRST(1)) u_a (
    .Clock_In(clk), .Reset_N_In(rst_v[0]), .Frame_Valid_In(valid_v[0]),
    .Frame_Ready_Out(ready_o[0]), .Frame_Data_In(data_v[0]),
`ifdef CHANNEL_MASK_EN
    .Channel_Mask_In(mask_v[0]),
`endif
    .Enable_Out(en_o[0]), .Data_Out(dat_o[0]), .Select_Out(sel_o[0]),
    .Frame_Done_Out(done_o[0]), .Busy_Out(busy_o[0])
  );

  demux_1_8_frame_sequencer #(.DWELL_CYCLES(3), .LSB_FIRST(0)) u_b (
    .Clock_In(clk), .Reset_N_In(rst_v[1]), .Frame_Valid_In(valid_v[1]),
    .Frame_Ready_Out(ready_o[1]), .Frame_Data_In(data_v[1]),
`ifdef CHANNEL_MASK_EN
    .Channel_Mask_In(mask_v[1]),
`endif
    .Enable_Out(en_o[1]), .Data_Out(dat_o[1]), .Select_Out(sel_o[1]),
    .Frame_Done_Out(done_o[1]), .Busy_Out(busy_o[1])
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       data;
    logic       done;
  } cyc_t;

  cyc_t exp_q[$];

  // Packed view: {enable, busy, select, data, done, ready}
  function automatic logic [7:0] obs(input int d);
    return {en_o[d], busy_o[d], sel_o[d], dat_o[d], done_o[d], ready_o[d]};
  endfunction

  // Reference: each enabled channel in scan order shown for `dwell` cycles; last cycle is Done.
  function automatic void push_frame(input int d, input logic [7:0] data, input logic [7:0] mask);
    int dwell;
    int total;
    int k;
    int ch;
    dwell = (d == 0) ? 1 : 3;
    total = $countones(mask) * dwell;
    k = 0;
    for (int s = 0; s < 8; s++) begin
      ch = (d == 0) ? s : 7 - s;
      if (mask[ch]) begin
        for (int w = 0; w < dwell; w++) begin
          exp_q.push_back('{sel: 3'(ch), data: data[ch], done: (k == total - 1)});
          k++;
        end
      end
    end
  endfunction

  task automatic wait_ready(input int d);
    int k;
    k = 0;
    while (ready_o[d] !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (ready_o[d] !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready dut%0d: ready=%b required 1", d, ready_o[d]);
    end
  endtask

  task automatic run(input string name, input int d, input logic [7:0] f0, input logic [7:0] m0,
                     input bit two, input logic [7:0] f1, input logic [7:0] m1);
    int n0;
    logic [7:0] exp;
    exp_q.delete();
    push_frame(d, f0, m0);
    n0 = exp_q.size();
    if (two) push_frame(d, f1, m1);
    wait_ready(d);
    valid_v[d] = 1'b1; data_v[d] = f0; mask_v[d] = m0;
    @(posedge clk); #1;
    valid_v[d] = two;
    data_v[d]  = two ? f1 : 8'($urandom);
    mask_v[d]  = two ? m1 : 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (two && i == n0) begin
        valid_v[d] = 1'b0;
        data_v[d]  = 8'($urandom);
      end
      exp = {1'b1, 1'b1, exp_q[i].sel, exp_q[i].data, exp_q[i].done, exp_q[i].done};
      n_vec++;
      if (obs(d) !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b required %b", name, i + 1, obs(d), exp);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (obs(d) !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL %s end: got %b required %b", name, obs(d), 8'b0000_0001);
    end
  endtask

  task automatic test_reset();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    valid_v[0] = 1'b0; valid_v[1] = 1'b0;
    data_v[0] = 8'h00; data_v[1] = 8'h00;
    mask_v[0] = 8'hFF; mask_v[1] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs(d) !== 8'b0000_0000) begin
        n_err++;
        $display("FAIL reset_values dut%0d: got %b required %b", d, obs(d), 8'b0000_0000);
      end
    end
    #1 rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs(d) !== 8'b0000_0001) begin
          n_err++;
          $display("FAIL reset_idle dut%0d cycle %0d: got %b required %b", d, c, obs(d), 8'b0000_0001);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    wait_ready(0);
    valid_v[0] = 1'b1; data_v[0] = 8'($urandom); mask_v[0] = 8'hFF;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    k = 0;
    while (sel_o[0] !== 3'd4 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (sel_o[0] !== 3'd4) begin
      n_err++;
      $display("FAIL mid_reset_reach_sel4: select=%0d required 4", sel_o[0]);
    end
    #2 rst_v[0] = 1'b0;
    #1;
    n_vec++;
    if (obs(0) !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL mid_reset_async: got %b required %b", obs(0), 8'b0000_0000);
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs(0) !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL mid_reset_held: got %b required %b", obs(0), 8'b0000_0000);
    end
    #1 rst_v[0] = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs(0) !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL mid_reset_release: got %b required %b", obs(0), 8'b0000_0001);
    end
    run("after_reset_01", 0, 8'h01, 8'hFF, 1'b0, 8'h00, 8'hFF);
  endtask

`ifdef CHANNEL_MASK_EN
  task automatic test_empty_mask(input int d);
    wait_ready(d);
    valid_v[d] = 1'b1; data_v[d] = 8'hFF; mask_v[d] = 8'h00;
    @(posedge clk); #1;
    valid_v[d] = 1'b0;
    n_vec++;
    if (obs(d) !== 8'b0000_0010) begin
      n_err++;
      $display("FAIL empty_mask_done dut%0d: got %b required %b", d, obs(d), 8'b0000_0010);
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs(d) !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL empty_mask_after dut%0d: got %b required %b", d, obs(d), 8'b0000_0001);
    end
  endtask
`endif

  task automatic test_random();
    int d;
    bit two;
    logic [7:0] f0, f1, m0, m1;
    for (int n = 0; n < 16; n++) begin
      d  = int'($urandom_range(0, 1));
      two = 1'($urandom_range(0, 1));
      f0 = 8'($urandom);
      f1 = 8'($urandom);
`ifdef CHANNEL_MASK_EN
      m0 = 8'($urandom_range(1, 255));
      m1 = 8'($urandom_range(1, 255));
`else
      m0 = 8'hFF;
      m1 = 8'hFF;
`endif
      run("random", d, f0, m0, two, f1, m1);
    end
  endtask

  initial begin
    test_reset();
    run("single_a5", 0, 8'hA5, 8'hFF, 1'b0, 8'h00, 8'hFF);
    run("back_to_back", 0, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF);
    run("dwell3_msb_80", 1, 8'h80, 8'hFF, 1'b0, 8'h00, 8'hFF);
    test_reset_mid_frame();
`ifdef CHANNEL_MASK_EN
    run("mask_81", 0, 8'hFF, 8'h81, 1'b0, 8'h00, 8'hFF);
    test_empty_mask(0);
    test_empty_mask(1);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1_8_frame_sequencer.md
Name: demux_1_8_frame_sequencer

Overview:
- Upstream driver for the 1:8 DEMUX: accepts 8-bit frames over a valid/ready handshake and serialises them, one bit per channel, onto the DEMUX Enable/Data/Select inputs.
- Channel index i carries frame bit i, so DEMUX output i reproduces frame bit i.
- Frame boundaries are signalled by Frame_Done_Out, and Busy_Out indicates a frame in flight.

Parameters:
- DWELL_CYCLES, 1, clock cycles each channel is presented. Legal range 1..255.
- LSB_FIRST, 1, 1 scans channel 0 up to 7; 0 scans channel 7 down to 0.

Ports:
- Clock_In  in  1  single clock, rising edge
- Reset_N_In  in  1  asynchronous active-low reset
- Frame_Valid_In  in  1  upstream frame valid
- Frame_Ready_Out  out  1  sequencer can accept a frame
- Frame_Data_In  in  8  frame bits; bit i goes to channel i
- Channel_Mask_In  in  8  per-channel enable; present only with CHANNEL_MASK_EN
- Enable_Out  out  1  to DEMUX Enable_In
- Data_Out  out  1  to DEMUX Data_In
- Select_Out  out  3  to DEMUX Select_In
- Frame_Done_Out  out  1  one-cycle pulse on the final cycle of a frame
- Busy_Out  out  1  high while a frame is being presented

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-low.
  - All outputs are registered.
- Reset values: Frame_Ready_Out=0, Enable_Out=0, Data_Out=0, Select_Out=3'd0, Frame_Done_Out=0, Busy_Out=0. Internal state is IDLE with counters cleared.
- Frame_Ready_Out rises on the first rising edge after reset deassertion.
- FSM states are IDLE and SCAN.
- IDLE:
  - Ready=1; Enable/Data/Select/Busy held at 0.
  - On Valid&&Ready at edge k: Frame_Data_In (and the mask) are captured into a shadow register, the channel index is set to 0 (LSB_FIRST=1) or 7, and the FSM moves to SCAN.
  - Ready=0 from edge k.
- SCAN:
  - Enable_Out=1, Busy_Out=1, Select_Out=index, Data_Out=shadow[index].
  - First channel is visible in the cycle after edge k (latency 1).
  - The dwell counter counts DWELL_CYCLES. On its terminal count the index advances by +1 or -1.
- Last channel, final dwell cycle:
  - Frame_Done_Out=1 for exactly that cycle, and Frame_Ready_Out=1 in that same cycle.
  - If Valid is high, the next frame is captured at that edge and SCAN continues with no idle gap: Enable_Out stays 1 and Frame_Done_Out pulses per frame.
  - Otherwise the FSM returns to IDLE: Enable_Out=0 and Select/Data return to 0.
- Frame length is 8*DWELL_CYCLES cycles.
- Frame_Valid_In while Ready=0 is ignored. Upstream holds data stable until accepted; changes to Frame_Data_In mid-frame do not affect the frame in flight.
- Index wrap is not possible: the index never steps past the last channel.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The frame is discarded with no Frame_Done_Out pulse.

Optional Feature:
- Macro: CHANNEL_MASK_EN.
- Defined:
  - Channel_Mask_In is captured with the frame. Channels whose mask bit is 0 are skipped in zero cycles, so frame length is popcount(mask)*DWELL_CYCLES.
  - Frame_Done_Out is asserted on the last unmasked channel.
  - Mask 8'h00: the frame is accepted, SCAN is not entered, Enable_Out stays 0, and Frame_Done_Out pulses in the cycle after acceptance. Ready then returns to 1.
- Undefined: the port is absent and all 8 channels are always scanned.

Decomposition:
- Package demux_seq_pkg holds:
  - typedef enum logic {IDLE, SCAN} seq_state_t
  - localparam NUM_CHANNELS=8
  - localparam SEL_WIDTH=3
  - localparam DWELL_WIDTH=8
- One sub-module, demux_dwell_counter: load/count with a terminal-count output, parameterised by DWELL_CYCLES.

Test Plan:
- Reset then idle: after Reset_N_In rises, Frame_Ready_Out=1 at the first edge; all other outputs stay 0 for 10 cycles with Valid=0.
- Single frame, DWELL=1, LSB_FIRST=1, Data=8'hA5:
  - Select_Out is 0..7 on cycles 1..8 after acceptance.
  - Data_Out is 1,0,1,0,0,1,0,1.
  - Frame_Done_Out is high only on the Select=7 cycle; Enable_Out=0 on cycle 9.
- Back-to-back: Valid held high with 8'hFF then 8'h00:
  - Enable_Out is continuously 1 for 16 cycles.
  - Data_Out is 8 ones then 8 zeros.
  - Frame_Done_Out pulses on cycles 8 and 16.
- DWELL=3, LSB_FIRST=0, Data=8'h80:
  - Each Select is held 3 cycles, 7 down to 0.
  - Data_Out=1 only during the first 3 cycles.
  - Frame lasts 24 cycles.
- Reset mid-frame at Select=4: Enable_Out drops to 0 asynchronously and no Frame_Done_Out pulse occurs. The next frame, 8'h01, restarts at Select=0.
- CHANNEL_MASK_EN:
  - Mask 8'b1000_0001, Data 8'hFF, DWELL=1: Select is 0 then 7, with Done on the second cycle.
  - Mask 8'h00: Done pulses one cycle after acceptance and Enable_Out is never 1.
